aes128_enc_iter: RTL and testbench

Iterative AES-128 encryption engine: accepts one plaintext block and one cipher key over a valid/ready handshake, runs the 10 FIPS-197 rounds with on-the-fly key expansion, and returns the ciphertext over a second valid/ready handshake. It is the sequential, parametrised successor to the single-cycle combinational round: the number of rounds evaluated per clock is configurable, and the final round omits MixColumns. It sits between the host/bus interface and the output buffer of the cryptoprocessor.

---
 rtl/aes_pkg.sv | 71 +++++++
 rtl/aes_round_unit.sv | 34 +++
 rtl/aes128_enc_iter.sv | 109 ++++++++++
 tb/tb_aes128_enc_iter.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES-128 primitives: S-box, GF(2^8) xtime, MixColumns column, rcon lookup,
// key-schedule step and the engine FSM state type.
package aes_pkg;

  localparam int unsigned NR = 10;
  localparam int unsigned BLK_W = 128;

  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_e;

  // Forward S-box, entry 0 in the most significant byte
  localparam logic [0:255][7:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TBL[b];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] rnd);
    logic [7:0] r;
    case (rnd)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  // One key-schedule step: RotWord, SubWord, rcon, then the word chain
  function automatic logic [127:0] key_expand(input logic [127:0] rk, input logic [7:0] rc);
    logic [31:0] w3, t, n0, n1, n2, n3;
    w3 = rk[31:0];
    t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rc, 24'h0};
    n0 = rk[127:96] ^ t;
    n1 = rk[95:64] ^ n0;
    n2 = rk[63:32] ^ n1;
    n3 = w3 ^ n2;
    return {n0, n1, n2, n3};
  endfunction

endpackage

// File: rtl/aes_round_unit.sv
// One combinational AES round; last=1 skips MixColumns for the final round.
module aes_round_unit
  import aes_pkg::*;
(
  input  logic [BLK_W-1:0] state_i,
  input  logic [BLK_W-1:0] rk_i,
  input  logic             last_i,
  output logic [BLK_W-1:0] state_o
);

  logic [7:0]  sb [16];
  logic [7:0]  sr [16];
  logic [31:0] col;

  always_comb begin
    col     = '0;
    state_o = '0;
    for (int i = 0; i < 16; i++) begin
      sb[i] = sbox(state_i[BLK_W-1-8*i -: 8]);
    end
    // Byte i sits at row i%4, column i/4; row r rotates left by r columns
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sr[4*c+r] = sb[4*((c+r)%4)+r];
      end
    end
    for (int c = 0; c < 4; c++) begin
      col = {sr[4*c], sr[4*c+1], sr[4*c+2], sr[4*c+3]};
      if (!last_i) col = mix_col(col);
      state_o[BLK_W-1-32*c -: 32] = col ^ rk_i[BLK_W-1-32*c -: 32];
    end
  end

endmodule

// File: rtl/aes128_enc_iter.sv
// Iterative AES-128 encryptor evaluating UNROLL rounds per clock with on-the-fly key expansion.
module aes128_enc_iter
  import aes_pkg::*;
#(
  parameter int unsigned UNROLL = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BLK_W-1:0] in_data,
  input  logic [BLK_W-1:0] in_key,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BLK_W-1:0] out_data
);

  if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 5 || UNROLL == 10)) begin : g_bad_unroll
    $error("aes128_enc_iter: UNROLL must be 1, 2, 5 or 10");
  end

  localparam logic [3:0] LAST_RND = 4'(NR - UNROLL + 1);

  fsm_e             fsm_q, fsm_d;
  logic [BLK_W-1:0] state_q, state_d;
  logic [BLK_W-1:0] rk_q, rk_d;
  logic [3:0]       rnd_q, rnd_d;
  logic [BLK_W-1:0] out_data_q, out_data_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;

  logic [BLK_W-1:0] st_chain [UNROLL+1];
  logic [BLK_W-1:0] rk_chain [UNROLL+1];

  assign st_chain[0] = state_q;
  assign rk_chain[0] = rk_q;

  // Round chain: stage u computes round rnd_q+u with its freshly expanded key
  for (genvar u = 0; u < UNROLL; u++) begin : g_round
    assign rk_chain[u+1] = key_expand(rk_chain[u], rcon(rnd_q + 4'(u)));

    aes_round_unit u_round (
      .state_i (st_chain[u]),
      .rk_i    (rk_chain[u+1]),
      .last_i  (rnd_q + 4'(u) == 4'(NR)),
      .state_o (st_chain[u+1])
    );
  end

  always_comb begin
    fsm_d      = fsm_q;
    state_d    = state_q;
    rk_d       = rk_q;
    rnd_d      = rnd_q;
    out_data_d = out_data_q;
    case (fsm_q)
      IDLE: begin
        if (in_valid) begin
          state_d = in_data ^ in_key;
          rk_d    = in_key;
          rnd_d   = 4'd1;
          fsm_d   = RUN;
        end
      end
      RUN: begin
        state_d = st_chain[UNROLL];
        rk_d    = rk_chain[UNROLL];
        // rnd holds on the final step so it never leaves 1..10
        if (rnd_q == LAST_RND) begin
          out_data_d = st_chain[UNROLL];
          fsm_d      = DONE;
        end else begin
          rnd_d = rnd_q + 4'(UNROLL);
        end
      end
      DONE: begin
        if (out_ready) fsm_d = IDLE;
      end
      default: fsm_d = IDLE;
    endcase
    in_ready_d  = (fsm_d == IDLE);
    out_valid_d = (fsm_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm_q       <= IDLE;
      state_q     <= '0;
      rk_q        <= '0;
      rnd_q       <= '0;
      out_data_q  <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      state_q     <= state_d;
      rk_q        <= rk_d;
      rnd_q       <= rnd_d;
      out_data_q  <= out_data_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_aes128_enc_iter.sv
// Directed FIPS-197 vectors across UNROLL=1/2/5/10 with latency, back-pressure and reset checks.
module tb_aes128_enc_iter;

  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] RK1_B = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid  [4];
  logic         in_ready  [4];
  logic [127:0] in_data   [4];
  logic [127:0] in_key    [4];
  logic         out_valid [4];
  logic         out_ready [4];
  logic [127:0] out_data  [4];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 4; g++) begin : gen_dut
    aes128_enc_iter #(.UNROLL((g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 5 : 10)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .in_data   (in_data[g]),
      .in_key    (in_key[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .out_data  (out_data[g])
    );
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept one block on DUT idx, measure edges until out_valid, check result, then drain
  task automatic encrypt(input int idx, input logic [127:0] pt, input logic [127:0] key,
                         input logic [127:0] exp, input int lat, input bit scramble,
                         input string tag);
    int n;
    n = 0;
    while (!in_ready[idx] && n < 50) begin
      tick();
      n++;
    end
    in_data[idx]   = pt;
    in_key[idx]    = key;
    in_valid[idx]  = 1'b1;
    out_ready[idx] = 1'b0;
    tick();
    in_valid[idx] = 1'b0;
    n = 0;
    while (!out_valid[idx] && n < 30) begin
      if (scramble) begin
        in_data[idx] = {$urandom, $urandom, $urandom, $urandom};
        in_key[idx]  = {$urandom, $urandom, $urandom, $urandom};
      end
      tick();
      n++;
    end
    check({tag, " latency"}, 128'(n), 128'(lat));
    check({tag, " data"}, out_data[idx], exp);
    check({tag, " in_ready low in DONE"}, 128'(in_ready[idx]), 128'(0));
    out_ready[idx] = 1'b1;
    tick();
    out_ready[idx] = 1'b0;
    check({tag, " out_valid drop"}, 128'(out_valid[idx]), 128'(0));
    check({tag, " in_ready back"}, 128'(in_ready[idx]), 128'(1));
  endtask

  initial begin
    int n;
    int t_first, t_second;
    logic [127:0] d_first, d_second;
    bit got_first, got_second;

    for (int i = 0; i < 4; i++) begin
      in_valid[i]  = 1'b0;
      out_ready[i] = 1'b0;
      in_data[i]   = '0;
      in_key[i]    = '0;
    end
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) begin
      check($sformatf("reset in_ready[%0d]", i), 128'(in_ready[i]), 128'(1));
      check($sformatf("reset out_valid[%0d]", i), 128'(out_valid[i]), 128'(0));
      check($sformatf("reset out_data[%0d]", i), out_data[i], 128'h0);
    end

    // App. B on UNROLL=1, including first round key
    in_data[0]  = PT_B;
    in_key[0]   = KEY_B;
    in_valid[0] = 1'b1;
    tick();
    in_valid[0] = 1'b0;
    tick();
    check("rk after round 1", gen_dut[0].u_dut.rk_q, RK1_B);
    n = 1;
    while (!out_valid[0] && n < 30) begin
      tick();
      n++;
    end
    check("appB latency", 128'(n), 128'(10));
    check("appB data", out_data[0], CT_B);
    out_ready[0] = 1'b1;
    tick();
    out_ready[0] = 1'b0;
    check("appB in_ready back", 128'(in_ready[0]), 128'(1));

    // App. C.1 on every UNROLL
    encrypt(0, PT_C, KEY_C, CT_C, 10, 1'b0, "C1 u1");
    encrypt(1, PT_C, KEY_C, CT_C, 5,  1'b0, "C1 u2");
    encrypt(2, PT_C, KEY_C, CT_C, 2,  1'b0, "C1 u5");
    encrypt(3, PT_C, KEY_C, CT_C, 1,  1'b0, "C1 u10");
    encrypt(1, PT_B, KEY_B, CT_B, 5,  1'b0, "B u2");

    // Back-pressure with an ignored in_valid pulse
    in_data[0]  = PT_B;
    in_key[0]   = KEY_B;
    in_valid[0] = 1'b1;
    tick();
    in_valid[0] = 1'b0;
    n = 0;
    while (!out_valid[0] && n < 30) begin
      tick();
      n++;
    end
    for (int i = 0; i < 20; i++) begin
      check("bp out_data hold", out_data[0], CT_B);
      check("bp in_ready low", 128'(in_ready[0]), 128'(0));
      check("bp out_valid hold", 128'(out_valid[0]), 128'(1));
      in_valid[0] = (i == 5);
      in_data[0]  = PT_C;
      in_key[0]   = KEY_C;
      tick();
    end
    in_valid[0]  = 1'b0;
    out_ready[0] = 1'b1;
    tick();
    out_ready[0] = 1'b0;
    check("bp release in_ready", 128'(in_ready[0]), 128'(1));
    check("bp release out_valid", 128'(out_valid[0]), 128'(0));
    check("bp out_data unchanged", out_data[0], CT_B);

    // Back-to-back: in_valid and out_ready held high
    in_data[0]   = PT_B;
    in_key[0]    = KEY_B;
    in_valid[0]  = 1'b1;
    out_ready[0] = 1'b1;
    tick();
    in_data[0] = PT_C;
    in_key[0]  = KEY_C;
    got_first  = 1'b0;
    got_second = 1'b0;
    t_first    = 0;
    t_second   = 0;
    d_first    = '0;
    d_second   = '0;
    n = 0;
    while (!got_second && n < 60) begin
      if (out_valid[0]) begin
        if (!got_first) begin
          got_first = 1'b1;
          t_first   = cyc;
          d_first   = out_data[0];
        end else begin
          got_second  = 1'b1;
          t_second    = cyc;
          d_second    = out_data[0];
          in_valid[0] = 1'b0;
        end
      end
      if (!got_second) tick();
      n++;
    end
    check("b2b first data", d_first, CT_B);
    check("b2b second data", d_second, CT_C);
    check("b2b period", 128'(t_second - t_first), 128'(12));
    tick();
    out_ready[0] = 1'b0;
    check("b2b idle after", 128'(in_ready[0]), 128'(1));
    check("b2b no extra accept", 128'(out_valid[0]), 128'(0));

    // Reset at round 5
    in_data[0]  = PT_B;
    in_key[0]   = KEY_B;
    in_valid[0] = 1'b1;
    tick();
    in_valid[0] = 1'b0;
    repeat (4) tick();
    check("pre-reset rnd", 128'(gen_dut[0].u_dut.rnd_q), 128'(5));
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mid reset out_valid", 128'(out_valid[0]), 128'(0));
    check("mid reset out_data", out_data[0], 128'h0);
    check("mid reset in_ready", 128'(in_ready[0]), 128'(1));
    check("mid reset state_reg", gen_dut[0].u_dut.state_q, 128'h0);
    check("mid reset rk_reg", gen_dut[0].u_dut.rk_q, 128'h0);
    check("mid reset rnd", 128'(gen_dut[0].u_dut.rnd_q), 128'(0));
    encrypt(0, PT_C, KEY_C, CT_C, 10, 1'b0, "post reset C1");

    // Inputs scrambled while running
    encrypt(0, PT_B, KEY_B, CT_B, 10, 1'b1, "stability u1");
    encrypt(1, PT_C, KEY_C, CT_C, 5,  1'b1, "stability u2");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
